// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_modexp engine.
//   state_t          : top-level FSM encoding
//   DEFAULT_WIDTH    : default operand width
//   modexp_latency() : accept-to-out_valid cycle count for a transaction
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        STEP,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Cycle (accept edge = 0) in which out_valid rises.
    function automatic int unsigned modexp_latency(
        input int unsigned width,
        input logic [31:0] modulus,
        input logic [31:0] exponent
    );
        int unsigned bit_len;
        bit_len = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (exponent[i]) bit_len = i + 1;
        end
        if (modulus <= 32'd1) return 1;
        if (exponent == '0) return width + 1;
        return width * (1 + bit_len) + 1;
    endfunction

endpackage

// File: rtl/rsa_modmul_serial.sv
// Bit-serial interleaved modular multiplier: p = (a * b) mod modulus.
// Precondition b < modulus; a is unrestricted.
//   clk, reset (sync, active-low)
//   start   : load operands; the first of WIDTH steps happens on this edge
//   a, b, modulus : operands, sampled when start is high
//   busy    : steps 2..WIDTH still pending
//   done    : one-cycle pulse, p valid from this cycle until next start
//   p       : partial/final product
module rsa_modmul_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_next;

    // t = 2p + (bit ? b : 0) < 3*modulus, so two conditional subtracts suffice.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] cur_p,
        input logic             cur_bit,
        input logic [WIDTH-1:0] cur_b,
        input logic [WIDTH-1:0] cur_m
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] m_ext;
        m_ext = {2'b00, cur_m};
        t = {1'b0, cur_p, 1'b0} + (cur_bit ? {2'b00, cur_b} : '0);
        if (t >= m_ext) t = t - m_ext;
        if (t >= m_ext) t = t - m_ext;
        return t[WIDTH-1:0];
    endfunction

    // On the start edge the first step uses the raw inputs with p = 0.
    always_comb begin
        p_next = '0;
        if (start) p_next = mm_step('0, a[WIDTH-1], b, modulus);
        else       p_next = mm_step(p, a_sh[WIDTH-1], b_r, m_r);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sh <= '0;
            b_r  <= '0;
            m_r  <= '0;
            cnt  <= '0;
            p    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            p    <= p_next;
            a_sh <= a << 1;
            b_r  <= b;
            m_r  <= modulus;
            cnt  <= CW'(1);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            p    <= p_next;
            a_sh <= a_sh << 1;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// One-shot modular exponentiation: result = message^exponent mod modulus.
// Right-to-left square-and-multiply over two bit-serial multipliers.
//   clk, reset (sync, active-low)
//   in_valid/in_ready   : operand handshake (message, exponent, modulus)
//   out_valid/out_ready : result handshake (result, err)
//   err                 : modulus was zero
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_t state, state_next;

    logic [WIDTH-1:0] e_q, m_q, acc_q;
    logic [WIDTH-1:0] e_next, acc_next, new_acc;
    logic [WIDTH-1:0] result_next;
    logic             err_next, load_result;

    logic             sq_start, sq_busy, sq_done;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] sq_a, sq_b, sq_p, mul_b, mul_p, mod_sel;

    // The square instance doubles as the REDUCE unit; its p holds base.
    rsa_modmul_serial #(.WIDTH(WIDTH)) u_square (
        .clk(clk), .reset(reset), .start(sq_start),
        .a(sq_a), .b(sq_b), .modulus(mod_sel),
        .busy(sq_busy), .done(sq_done), .p(sq_p)
    );

    rsa_modmul_serial #(.WIDTH(WIDTH)) u_multiply (
        .clk(clk), .reset(reset), .start(mul_start),
        .a(sq_p), .b(mul_b), .modulus(mod_sel),
        .busy(mul_busy), .done(mul_done), .p(mul_p)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mod_sel   = (state == IDLE) ? modulus : m_q;
    assign e_next    = e_q >> 1;
    assign new_acc   = e_q[0] ? mul_p : acc_q;

    always_comb begin
        state_next  = state;
        sq_start    = 1'b0;
        mul_start   = 1'b0;
        sq_a        = sq_p;
        sq_b        = sq_p;
        mul_b       = acc_q;
        acc_next    = acc_q;
        result_next = result;
        err_next    = err;
        load_result = 1'b0;
        unique case (state)
            IDLE: begin
                sq_a = message;
                sq_b = WIDTH'(1);
                if (in_valid) begin
                    if (modulus <= WIDTH'(1)) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        result_next = '0;
                        err_next    = (modulus == '0);
                    end else begin
                        state_next = REDUCE;
                        sq_start   = 1'b1;
                    end
                end
            end
            REDUCE: begin
                if (sq_done && !sq_busy) begin
                    acc_next = WIDTH'(1);
                    if (e_q == '0) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        result_next = WIDTH'(1);
                        err_next    = 1'b0;
                    end else begin
                        state_next = STEP;
                        sq_start   = 1'b1;
                        mul_start  = 1'b1;
                        mul_b      = WIDTH'(1);
                    end
                end
            end
            STEP: begin
                // Both multipliers were started together and finish together.
                if (sq_done && mul_done && !mul_busy) begin
                    acc_next = new_acc;
                    if (e_next == '0) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        result_next = new_acc;
                        err_next    = 1'b0;
                    end else begin
                        sq_start  = 1'b1;
                        mul_start = 1'b1;
                        mul_b     = new_acc;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            e_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            acc_q <= acc_next;
            if (state == IDLE && in_valid) begin
                e_q <= exponent;
                m_q <= modulus;
            end else if (state == STEP && sq_done) begin
                e_q <= e_next;
            end
            if (load_result) begin
                result <= result_next;
                err    <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp.sv
module tb_rsa_modexp;
    import rsa_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] message = '0;
    logic [W-1:0] exponent = '0;
    logic [W-1:0] modulus = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         err;

    int unsigned total = 0;
    int unsigned bad = 0;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .message(message), .exponent(exponent), .modulus(modulus),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic start_txn(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        message  = m;
        exponent = e;
        modulus  = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        message  = $urandom;
        exponent = $urandom;
        modulus  = $urandom;
    endtask

    // Called #1 after the accept edge, i.e. in cycle 1.
    task automatic wait_result(input string tag, input int unsigned lat,
                               input logic [W-1:0] res, input logic e, input bit ack);
        int unsigned cyc;
        cyc = 1;
        while (!out_valid && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_result"}, result, res);
        chk({tag, "_err"}, 32'(err), 32'(e));
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        start_txn(32'd4, 32'd13, 32'd497);
        wait_result("basic", 161, 32'd445, 1'b0, 1'b1);

        start_txn(32'd65, 32'd17, 32'd3233);
        wait_result("rsa_enc", modexp_latency(W, 32'd3233, 32'd17), 32'd2790, 1'b0, 1'b1);

        start_txn(32'd2790, 32'd2753, 32'd3233);
        wait_result("rsa_dec", modexp_latency(W, 32'd3233, 32'd2753), 32'd65, 1'b0, 1'b1);

        start_txn(32'd5, 32'd0, 32'd7);
        wait_result("exp_zero", 33, 32'd1, 1'b0, 1'b1);

        start_txn(32'd1000, 32'd1, 32'd7);
        wait_result("big_msg", 65, 32'd6, 1'b0, 1'b1);

        start_txn(32'd9, 32'd3, 32'd0);
        wait_result("mod_zero", 1, 32'd0, 1'b1, 1'b1);

        start_txn(32'd9, 32'd3, 32'd1);
        wait_result("mod_one", 1, 32'd0, 1'b0, 1'b1);

        // Back-pressure: result held, second request ignored until handshake.
        start_txn(32'd4, 32'd13, 32'd497);
        wait_result("stall", 161, 32'd445, 1'b0, 1'b0);
        message  = 32'd5;
        exponent = 32'd0;
        modulus  = 32'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("stall_result", result, 32'd445);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_valid_drop", 32'(out_valid), 32'd0);
        chk("stall_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("second", 33, 32'd1, 1'b0, 1'b1);

        // Abort mid-STEP.
        start_txn(32'd65, 32'd17, 32'd3233);
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_txn(32'd4, 32'd13, 32'd497);
        wait_result("after_abort", 161, 32'd445, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
